// File: rtl/row_mac_sequencer.sv
// Per-row dot-product sequencer: for each accepted row it clears the external
// accumulator, streams N_COLS operand reads (A[row][col], x[col]) through the
// shared operand port, waits for the MAC pipeline to drain, writes the result
// to result memory and pulses done_row.
//
// Ports:
//   clk, n_reset             clock (rising edge), async active-low reset
//   begin_mult, res_add      row request and row index / result address
//   mem_ready                operand port grant
//   op_rd_en, a_addr, x_addr operand read strobe and addresses
//   acc_clear, acc_en        accumulator clear and accumulate enable
//   res_wr_en, res_wr_addr   result memory write
//   done_row, busy           completion pulse and activity flag
module row_mac_sequencer #(
    parameter int unsigned N_ROWS   = 10,
    parameter int unsigned N_COLS   = 10,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned A_ADDR_W = 7,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                begin_mult,
    input  logic [IDX_W-1:0]    res_add,
    input  logic                mem_ready,
    output logic                op_rd_en,
    output logic [A_ADDR_W-1:0] a_addr,
    output logic [IDX_W-1:0]    x_addr,
    output logic                acc_clear,
    output logic                acc_en,
    output logic                res_wr_en,
    output logic [IDX_W-1:0]    res_wr_addr,
    output logic                done_row,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(N_COLS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   row_q, row_d;
    logic [IDX_W-1:0]   col_q, col_d;
    logic [RD_LAT-1:0]  pipe_q;

    // State, indices and read-valid pipe; the pipe shifts every cycle, stalls included.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pipe_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pipe_q[0] <= op_rd_en;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        op_rd_en  = 1'b0;
        acc_clear = 1'b0;
        res_wr_en = 1'b0;
        done_row  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (begin_mult) begin
                    row_d = res_add;
                    // Out-of-range rows skip straight to DONE so the controller still sees done_row.
                    state_d = (32'(res_add) < N_ROWS) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: begin
                acc_clear = 1'b1;
                col_d     = '0;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                op_rd_en = mem_ready;
                if (mem_ready) begin
                    if (col_q == LAST_COL) begin
                        state_d = S_DRAIN;
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Empty pipe means the last product has already been accumulated.
                if (pipe_q == '0) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                res_wr_en = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done_row = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign acc_en      = pipe_q[RD_LAT-1];
    assign busy        = (state_q != S_IDLE);
    assign a_addr      = A_ADDR_W'(row_q) * A_ADDR_W'(N_COLS) + A_ADDR_W'(col_q);
    assign x_addr      = col_q;
    assign res_wr_addr = row_q;

endmodule

// File: tb/tb_row_mac_sequencer.sv
// Self-checking bench for row_mac_sequencer with a transaction-level model of
// the expected read stream, accumulate timing and row completion.
module tb_row_mac_sequencer;
    localparam int unsigned N_ROWS   = 10;
    localparam int unsigned N_COLS   = 10;
    localparam int unsigned A_ADDR_W = 7;
    localparam int unsigned IDX_W    = 4;
    parameter  int unsigned RD_LAT   = 1;

    logic                clk = 1'b0;
    logic                n_reset = 1'b0;
    logic                begin_mult = 1'b0;
    logic [IDX_W-1:0]    res_add = '0;
    logic                mem_ready = 1'b0;
    logic                op_rd_en;
    logic [A_ADDR_W-1:0] a_addr;
    logic [IDX_W-1:0]    x_addr;
    logic                acc_clear;
    logic                acc_en;
    logic                res_wr_en;
    logic [IDX_W-1:0]    res_wr_addr;
    logic                done_row;
    logic                busy;

    int total = 0;
    int bad   = 0;
    int total_reads = 0;
    int obs_done = -1;
    int wr_q[$];

    row_mac_sequencer #(
        .N_ROWS(N_ROWS), .N_COLS(N_COLS), .RD_LAT(RD_LAT),
        .A_ADDR_W(A_ADDR_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .n_reset(n_reset), .begin_mult(begin_mult), .res_add(res_add),
        .mem_ready(mem_ready), .op_rd_en(op_rd_en), .a_addr(a_addr), .x_addr(x_addr),
        .acc_clear(acc_clear), .acc_en(acc_en), .res_wr_en(res_wr_en),
        .res_wr_addr(res_wr_addr), .done_row(done_row), .busy(busy)
    );

    always #5 clk = ~clk;

    // Every output must be zero (used while reset is asserted).
    task automatic check_all_zero(input string tag);
        total++;
        if ({op_rd_en, acc_en, acc_clear, res_wr_en, done_row, busy} !== 6'b0 ||
            a_addr !== '0 || x_addr !== '0 || res_wr_addr !== '0) begin
            bad++;
            $display("FAIL %s: outputs not zero strobes=%b a_addr=%0d x_addr=%0d wr_addr=%0d",
                     tag, {op_rd_en, acc_en, acc_clear, res_wr_en, done_row, busy},
                     a_addr, x_addr, res_wr_addr);
        end
    endtask

    // Idle cycles with begin_mult low: nothing may happen.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            begin_mult = 1'b0;
            mem_ready  = 1'($urandom_range(0, 1));
            #1;
            total++;
            if ({op_rd_en, res_wr_en, done_row, busy, acc_clear} !== 5'b0) begin
                bad++;
                $display("FAIL idle: strobes op/wr/done/busy/clr=%b expected 00000",
                         {op_rd_en, res_wr_en, done_row, busy, acc_clear});
            end
        end
    endtask

    // Run one request from its accepting IDLE cycle (t=0) to done_row.
    // mode 0: mem_ready always 1; 1: 3-cycle stall at col 5; 2: random grant and noise.
    // abort_at >= 0 asserts reset in that cycle and returns with reset held.
    task automatic run_row(input int row, input int mode, input int abort_at, input bit hold);
        int  reads = 0, accs = 0, wrs = 0, stalls = 0, stall_left = 3, exp_done = 0;
        bit  in_range = (row < int'(N_ROWS));
        bit  finished = 1'b0;
        bit  rd_hist [0:511];
        for (int i = 0; i < 512; i++) rd_hist[i] = 1'b0;
        obs_done = -1;
        for (int t = 0; t < 400 && !finished; t++) begin
            bit mr, issuing, e_op, e_acc, e_clr, e_wr, e_dn, e_busy;
            @(negedge clk);
            if (t == abort_at) begin
                mem_ready  = 1'b1;
                begin_mult = 1'b0;
                n_reset    = 1'b0;
                #1;
                check_all_zero("reset_mid_row");
                return;
            end
            issuing = in_range && t >= 2 && reads < int'(N_COLS);
            case (mode)
                0:       mr = 1'b1;
                1:       mr = !(issuing && reads == 5 && stall_left > 0);
                default: mr = ($urandom_range(0, 3) != 0);
            endcase
            mem_ready = mr;
            if (t == 0) begin
                begin_mult = 1'b1;
                res_add    = IDX_W'(row);
            end else if (hold) begin
                begin_mult = 1'b1;
            end else if (mode == 2) begin
                begin_mult = 1'($urandom_range(0, 1));
                res_add    = IDX_W'($urandom);
            end else begin
                begin_mult = 1'b0;
            end
            #1;
            exp_done = in_range ? int'(N_COLS + RD_LAT + 4) + stalls : 1;
            e_op   = issuing && mr;
            e_acc  = (t >= int'(RD_LAT)) && rd_hist[t - int'(RD_LAT)];
            e_clr  = in_range && t == 1;
            e_wr   = in_range && reads == int'(N_COLS) && t == exp_done - 1;
            e_dn   = (!in_range || reads == int'(N_COLS)) && t == exp_done;
            e_busy = t > 0 && t <= exp_done;
            total += 6;
            if (op_rd_en !== e_op) begin
                bad++; $display("FAIL op_rd_en t=%0d row=%0d got=%b exp=%b", t, row, op_rd_en, e_op);
            end
            if (acc_en !== e_acc) begin
                bad++; $display("FAIL acc_en t=%0d row=%0d got=%b exp=%b", t, row, acc_en, e_acc);
            end
            if (acc_clear !== e_clr) begin
                bad++; $display("FAIL acc_clear t=%0d row=%0d got=%b exp=%b", t, row, acc_clear, e_clr);
            end
            if (res_wr_en !== e_wr) begin
                bad++; $display("FAIL res_wr_en t=%0d row=%0d got=%b exp=%b", t, row, res_wr_en, e_wr);
            end
            if (done_row !== e_dn) begin
                bad++; $display("FAIL done_row t=%0d row=%0d got=%b exp=%b", t, row, done_row, e_dn);
            end
            if (busy !== e_busy) begin
                bad++; $display("FAIL busy t=%0d row=%0d got=%b exp=%b", t, row, busy, e_busy);
            end
            // Addresses must point at the next unread element, including while stalled.
            if (issuing) begin
                total++;
                if (a_addr !== A_ADDR_W'(row * int'(N_COLS) + reads) || x_addr !== IDX_W'(reads)) begin
                    bad++;
                    $display("FAIL addr t=%0d row=%0d got a=%0d x=%0d exp a=%0d x=%0d",
                             t, row, a_addr, x_addr, row * int'(N_COLS) + reads, reads);
                end
            end
            if (res_wr_en === 1'b1) begin
                wr_q.push_back(int'(res_wr_addr));
                total++;
                if (res_wr_addr !== IDX_W'(row)) begin
                    bad++; $display("FAIL res_wr_addr row=%0d got=%0d", row, res_wr_addr);
                end
            end
            if (op_rd_en === 1'b1) total_reads++;
            if (acc_en === 1'b1) accs++;
            if (res_wr_en === 1'b1) wrs++;
            if (done_row === 1'b1 && obs_done < 0) obs_done = t;
            if (e_op) begin
                rd_hist[t] = 1'b1;
                reads++;
            end
            if (issuing && !mr) begin
                stalls++;
                if (mode == 1) stall_left--;
            end
            if (e_dn) finished = 1'b1;
        end
        total += 3;
        if (!finished) begin
            bad++; $display("FAIL timeout row=%0d no completion within bound", row);
        end
        if (accs != (in_range ? int'(N_COLS) : 0)) begin
            bad++; $display("FAIL acc_count row=%0d got=%0d", row, accs);
        end
        if (wrs != (in_range ? 1 : 0)) begin
            bad++; $display("FAIL wr_count row=%0d got=%0d", row, wrs);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        n_reset = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_single_row();
        run_row(3, 0, -1, 1'b0);
        total++;
        if (obs_done != int'(N_COLS + RD_LAT + 4)) begin
            bad++; $display("FAIL single_latency got=%0d exp=%0d", obs_done, N_COLS + RD_LAT + 4);
        end
        idle_cycles(2);
    endtask

    task automatic test_stall();
        run_row(6, 1, -1, 1'b0);
        total++;
        if (obs_done != int'(N_COLS + RD_LAT + 7)) begin
            bad++; $display("FAIL stall_latency got=%0d exp=%0d", obs_done, N_COLS + RD_LAT + 7);
        end
        idle_cycles(2);
    endtask

    task automatic test_out_of_range();
        run_row(12, 0, -1, 1'b0);
        total++;
        if (obs_done != 1) begin
            bad++; $display("FAIL oor_latency got=%0d exp=1", obs_done);
        end
        run_row(15, 2, -1, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        int reads0 = total_reads;
        wr_q.delete();
        for (int r = 0; r < int'(N_ROWS); r++) run_row(r, 0, -1, 1'b1);
        idle_cycles(2);
        total += 2;
        if (total_reads - reads0 != int'(N_ROWS * N_COLS)) begin
            bad++; $display("FAIL b2b_reads got=%0d exp=%0d", total_reads - reads0, N_ROWS * N_COLS);
        end
        if (wr_q.size() != int'(N_ROWS)) begin
            bad++; $display("FAIL b2b_writes got=%0d exp=%0d", wr_q.size(), N_ROWS);
        end
        for (int i = 0; i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i] != i) begin
                bad++; $display("FAIL b2b_order idx=%0d got=%0d", i, wr_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_row();
        run_row(7, 0, 6, 1'b0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check_all_zero("reset_hold");
        end
        @(negedge clk);
        n_reset = 1'b1;
        idle_cycles(5);
        run_row(2, 0, -1, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_row(int'($urandom_range(0, 15)), 2, -1, 1'b0);
            idle_cycles(int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_stall();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_row();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
